// File: rtl/spi_glue_if.sv
// SPI-slave-facing and sample-stream signals of spi_glue, bundled for a single port.
// The slave modport is the glue's view; the master modport is the driving side.
interface spi_glue_if;
    logic       spi_cs_i;
    logic       spi_octet_i;
    logic [7:0] spi_rx_i;
    logic [7:0] spi_tx_o;
    logic [7:0] sample_o;
    logic       sample_valid_o;
    logic       sample_ready_i;

    modport slave (
        input  spi_cs_i, spi_octet_i, spi_rx_i, sample_ready_i,
        output spi_tx_o, sample_o, sample_valid_o
    );

    modport master (
        output spi_cs_i, spi_octet_i, spi_rx_i, sample_ready_i,
        input  spi_tx_o, sample_o, sample_valid_o
    );
endinterface

// File: rtl/spi_glue.sv
// Command/data front end behind the SPI slave: register bank, sample FIFO and MISO byte source.
// Optional error counter at 0x7E is built when SPI_GLUE_ERRCNT_EN is defined.
module spi_glue #(
    parameter int NREG        = 8,
    parameter int FIFO_DEPTH  = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic              clk_i,
    input  logic              rst_n_i,
    spi_glue_if.slave         bus,
    output logic [NREG*8-1:0] regs_o
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam logic [6:0] ADDR_FIFO = 7'h40;
    localparam logic [6:0] ADDR_STAT = 7'h7F;
`ifdef SPI_GLUE_ERRCNT_EN
    localparam logic [6:0] ADDR_ERR  = 7'h7E;
`endif

    typedef enum logic [1:0] {IDLE, CMD, DATA} state_e;

    logic [SYNC_STAGES-1:0] cs_sync_q, oct_sync_q;
    logic [7:0]             rx_sync_q [SYNC_STAGES];
    logic                   oct_d1_q;
    logic                   cs_s, oct_s, byte_evt;
    logic [7:0]             rx_s;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            cs_sync_q  <= '0;
            oct_sync_q <= '0;
            oct_d1_q   <= 1'b0;
        end else begin
            cs_sync_q  <= {cs_sync_q[SYNC_STAGES-2:0], bus.spi_cs_i};
            oct_sync_q <= {oct_sync_q[SYNC_STAGES-2:0], bus.spi_octet_i};
            oct_d1_q   <= oct_s;
        end
    end

    always_ff @(posedge clk_i) begin
        rx_sync_q[0] <= bus.spi_rx_i;
        for (int i = 1; i < SYNC_STAGES; i++) rx_sync_q[i] <= rx_sync_q[i-1];
    end

    assign cs_s     = cs_sync_q[SYNC_STAGES-1];
    assign oct_s    = oct_sync_q[SYNC_STAGES-1];
    assign rx_s     = rx_sync_q[SYNC_STAGES-1];
    assign byte_evt = oct_d1_q & ~oct_s;

    state_e     state_q, state_d;
    logic       armed_q;
    logic       rw_q, rw_d;
    logic [6:0] addr_q, addr_d;
    logic [7:0] tx_q, tx_d;
    logic [7:0] regs_q [NREG];
    logic       reg_we, push_req, ovf_clr;

    logic [7:0]    mem_q [FIFO_DEPTH];
    logic [AW-1:0] wp_q, rp_q, rp_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [7:0]    head_q, head_d;
    logic          valid_q, ovf_q;
    logic          full, empty, pop_ok, push_ok, drop;
    logic [7:0]    status;

`ifdef SPI_GLUE_ERRCNT_EN
    logic [7:0] err_q;
    logic [7:0] rx_d1_q;
    logic       sck_seen_q, err_clr, cmd_abort;
`endif

    function automatic logic [3:0] sat_level(input logic [CW-1:0] c);
        return (int'(c) > 15) ? 4'hF : 4'(c);
    endfunction

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    assign full   = (cnt_q == CW'(FIFO_DEPTH));
    assign empty  = (cnt_q == '0);
    assign status = {full, empty, ovf_q, 1'b0, sat_level(cnt_q)};

    function automatic logic [7:0] rd_val(input logic [6:0] a);
        logic [7:0] v;
        v = 8'h00;
        for (int i = 0; i < NREG; i++) if (a == 7'(i)) v = regs_q[i];
        if (a == ADDR_STAT) v = status;
`ifdef SPI_GLUE_ERRCNT_EN
        if (a == ADDR_ERR) v = err_q;
`endif
        return v;
    endfunction

    // Leaving IDLE requires a synced CS high first, so a frame interrupted by reset is ignored.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q <= IDLE;
            armed_q <= 1'b0;
        end else begin
            state_q <= state_d;
            if (cs_s) armed_q <= 1'b1;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (armed_q && !cs_s) state_d = CMD;
            CMD:     if (cs_s) state_d = IDLE;
                     else if (byte_evt) state_d = DATA;
            DATA:    if (cs_s) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        addr_d   = addr_q;
        rw_d     = rw_q;
        tx_d     = tx_q;
        reg_we   = 1'b0;
        push_req = 1'b0;
        ovf_clr  = 1'b0;
`ifdef SPI_GLUE_ERRCNT_EN
        err_clr  = 1'b0;
`endif
        if (!cs_s && byte_evt) begin
            if (state_q == CMD) begin
                rw_d   = rx_s[7];
                addr_d = rx_s[6:0];
                tx_d   = rd_val(rx_s[6:0]);
            end else if (state_q == DATA) begin
                if (rw_q) begin
                    reg_we   = (int'(addr_q) < NREG);
                    push_req = (addr_q == ADDR_FIFO);
`ifdef SPI_GLUE_ERRCNT_EN
                    err_clr  = (addr_q == ADDR_ERR);
`endif
                end else begin
                    ovf_clr = (addr_q == ADDR_STAT);
                end
                if (addr_q != ADDR_FIFO) addr_d = addr_q + 7'd1;
                tx_d = rd_val(addr_d);
            end
        end
        if (state_d != DATA) tx_d = 8'hA5;
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            rw_q   <= 1'b0;
            addr_q <= '0;
            tx_q   <= 8'hA5;
            for (int i = 0; i < NREG; i++) regs_q[i] <= '0;
        end else begin
            rw_q   <= rw_d;
            addr_q <= addr_d;
            tx_q   <= tx_d;
            for (int i = 0; i < NREG; i++)
                if (reg_we && addr_q == 7'(i)) regs_q[i] <= rx_s;
        end
    end

    for (genvar g = 0; g < NREG; g++) begin : g_flat
        assign regs_o[8*g +: 8] = regs_q[g];
    end

    // A push into a full FIFO still lands when the same cycle pops a slot free.
    assign pop_ok  = valid_q & bus.sample_ready_i;
    assign push_ok = push_req & (~full | pop_ok);
    assign drop    = push_req & full & ~pop_ok;
    assign rp_d    = pop_ok ? rp_q + AW'(1) : rp_q;

    always_comb begin
        cnt_d = cnt_q;
        if (push_ok && !pop_ok)      cnt_d = cnt_q + CW'(1);
        else if (!push_ok && pop_ok) cnt_d = cnt_q - CW'(1);
        head_d = (push_ok && wp_q == rp_d) ? rx_s : mem_q[rp_d];
    end

    always_ff @(posedge clk_i) begin
        if (push_ok) mem_q[wp_q] <= rx_s;
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            wp_q    <= '0;
            rp_q    <= '0;
            cnt_q   <= '0;
            head_q  <= '0;
            valid_q <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            if (push_ok) wp_q <= wp_q + AW'(1);
            rp_q    <= rp_d;
            cnt_q   <= cnt_d;
            valid_q <= (cnt_d != '0);
            if (cnt_d != '0) head_q <= head_d;
            if (drop) ovf_q <= 1'b1;
            else if (ovf_clr) ovf_q <= 1'b0;
        end
    end

`ifdef SPI_GLUE_ERRCNT_EN
    // Receive-byte movement stands in for SCK activity when judging an aborted command.
    assign cmd_abort = (state_q == CMD) & cs_s & sck_seen_q;

    always_ff @(posedge clk_i) begin
        rx_d1_q <= rx_s;
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            err_q      <= '0;
            sck_seen_q <= 1'b0;
        end else begin
            if (state_q != CMD) sck_seen_q <= 1'b0;
            else if (rx_s != rx_d1_q || (oct_s && !oct_d1_q)) sck_seen_q <= 1'b1;
            if (err_clr) err_q <= '0;
            else if (drop || cmd_abort) err_q <= sat_inc8(err_q);
        end
    end
`endif

    assign bus.spi_tx_o       = tx_q;
    assign bus.sample_o       = head_q;
    assign bus.sample_valid_o = valid_q;
endmodule

// File: tb/tb_spi_glue.sv
// Directed bench for spi_glue: register bursts, readback, FIFO streaming, abort, wrap, reset mid-frame.
module tb_spi_glue;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [63:0] regs;
    int          n_vec = 0;
    int          n_err = 0;

    spi_glue_if bus();

    spi_glue #(.NREG(8), .FIFO_DEPTH(16), .SYNC_STAGES(2)) dut (
        .clk_i  (clk),
        .rst_n_i(rst_n),
        .bus    (bus.slave),
        .regs_o (regs)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic cs_low();
        bus.spi_cs_i = 1'b0;
        tick(6);
    endtask

    task automatic cs_high();
        bus.spi_cs_i = 1'b1;
        tick(6);
    endtask

    // One received octet; with pop set, sample_ready_i is high exactly at the byte-event edge.
    task automatic send(input logic [7:0] b, input bit pop);
        bus.spi_rx_i = b;
        tick(2);
        bus.spi_octet_i = 1'b1;
        tick(3);
        bus.spi_octet_i = 1'b0;
        tick(2);
        if (pop) bus.sample_ready_i = 1'b1;
        tick(1);
        bus.sample_ready_i = 1'b0;
        tick(3);
    endtask

    task automatic read_status(input string tag, input logic [7:0] exp);
        cs_low();
        send(8'h7F, 1'b0);
        check(tag, bus.spi_tx_o, exp);
        cs_high();
    endtask

    task automatic drain(input string tag, input logic [7:0] first, input logic [7:0] last);
        bus.sample_ready_i = 1'b1;
        for (int i = 0; i < 16; i++) begin
            logic [7:0] e;
            e = (i < 15) ? first + 8'(i) : last;
            check(tag, {bus.sample_valid_o, bus.sample_o}, {1'b1, e});
            tick(1);
        end
        bus.sample_ready_i = 1'b0;
        check({tag, "_empty"}, bus.sample_valid_o, 1'b0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bus.spi_cs_i = 1'b1; bus.spi_octet_i = 1'b0; bus.spi_rx_i = 8'h00; bus.sample_ready_i = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            bus.spi_cs_i = 1'($urandom); bus.spi_octet_i = 1'($urandom);
            bus.spi_rx_i = 8'($urandom); bus.sample_ready_i = 1'($urandom);
        end
        @(negedge clk);
        check("rst_regs", regs, 64'h0);
        check("rst_valid", bus.sample_valid_o, 1'b0);
        check("rst_tx", bus.spi_tx_o, 8'hA5);
        check("rst_sample", bus.sample_o, 8'h00);
        bus.spi_cs_i = 1'b1; bus.spi_octet_i = 1'b0; bus.spi_rx_i = 8'h00; bus.sample_ready_i = 1'b0;
        tick(2);
        rst_n = 1'b1;
        tick(4);

        cs_low();
        send(8'h82, 1'b0); send(8'h11, 1'b0); send(8'h22, 1'b0);
        cs_high();
        check("burst_regs", regs, 64'h0000_0000_2211_0000);

        cs_low();
        check("cmd_marker", bus.spi_tx_o, 8'hA5);
        send(8'h02, 1'b0);
        check("rd_byte2", bus.spi_tx_o, 8'h11);
        send(8'h00, 1'b0);
        check("rd_byte3", bus.spi_tx_o, 8'h22);
        cs_high();
        check("idle_marker", bus.spi_tx_o, 8'hA5);

        cs_low();
        send(8'hC0, 1'b0);
        for (int i = 0; i < 20; i++) send(8'(i), 1'b0);
        cs_high();
        check("stream_head", {bus.sample_valid_o, bus.sample_o}, 9'h100);
        cs_low();
        send(8'h7F, 1'b0);
        check("stat_full_ovf", bus.spi_tx_o, 8'hAF);
        send(8'h00, 1'b0);
        check("stat_wrap_reg0", bus.spi_tx_o, 8'h00);
        cs_high();
`ifdef SPI_GLUE_ERRCNT_EN
        cs_low(); send(8'h7E, 1'b0);
        check("errcnt_drops", bus.spi_tx_o, 8'h04);
        cs_high();
`endif
        drain("pop", 8'h00, 8'h0F);
        read_status("stat_empty", 8'h40);

        bus.spi_cs_i = 1'b0;
        tick(6);
        for (int k = 0; k < 4; k++) begin
            bus.spi_rx_i = {bus.spi_rx_i[6:0], ~bus.spi_rx_i[0]};
            tick(2);
        end
        cs_high();
        check("abort_regs", regs, 64'h0000_0000_2211_0000);
        cs_low();
        send(8'h81, 1'b0); send(8'h5A, 1'b0);
        cs_high();
        check("after_abort", regs, 64'h0000_0000_2211_5A00);
`ifdef SPI_GLUE_ERRCNT_EN
        cs_low(); send(8'h7E, 1'b0);
        check("errcnt_abort", bus.spi_tx_o, 8'h05);
        cs_high();
`endif

        cs_low();
        send(8'hFF, 1'b0);
        check("wrap_stat", bus.spi_tx_o, 8'h40);
        send(8'h33, 1'b0);
        check("wrap_tx0", bus.spi_tx_o, 8'h00);
        send(8'h77, 1'b0);
        check("wrap_tx1", bus.spi_tx_o, 8'h5A);
        cs_high();
        check("wrap_regs", regs, 64'h0000_0000_2211_5A77);
        read_status("wrap_stat_after", 8'h40);

        cs_low();
        send(8'hC0, 1'b0);
        for (int i = 0; i < 16; i++) send(8'h80 + 8'(i), 1'b0);
        send(8'h90, 1'b1);
        cs_high();
        check("pushpop_head", {bus.sample_valid_o, bus.sample_o}, 9'h181);
        read_status("stat_full_noovf", 8'h8F);
        drain("pushpop", 8'h81, 8'h90);

        cs_low();
        send(8'h84, 1'b0);
        rst_n = 1'b0;
        tick(2);
        check("midrst_regs", regs, 64'h0);
        check("midrst_tx", bus.spi_tx_o, 8'hA5);
        rst_n = 1'b1;
        tick(4);
        send(8'h99, 1'b0); send(8'h55, 1'b0);
        check("midrst_ignored", regs, 64'h0);
        cs_high();
        cs_low();
        send(8'h84, 1'b0); send(8'h99, 1'b0);
        cs_high();
        check("midrst_recover", regs, 64'h0000_0099_0000_0000);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
